// File: rtl/mcf_sink_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mcf_sink_pkg
//  Purpose  : Shared constants, state encoding and helpers for the McF
//             stream sink (settings addresses, readback map, CVITA sizes).
//  Revision : 1.0 - initial release
// ============================================================================
package mcf_sink_pkg;

  // Settings-bus addresses
  localparam logic [7:0] SR_SINK_ENABLE_DFLT    = 8'd4;
  localparam logic [7:0] SR_SINK_SPP_DFLT       = 8'd5;
  localparam logic [7:0] SR_SINK_READY_DIV_DFLT = 8'd6;
  localparam logic [7:0] SR_SINK_CLEAR_DFLT     = 8'd7;

  // Settings reset values
  localparam logic [15:0] SPP_RESET       = 16'd768;
  localparam logic [15:0] READY_DIV_RESET = 16'd1;

  // Readback map
  localparam logic [2:0] RB_COUNTS   = 3'd0;
  localparam logic [2:0] RB_ERRORS   = 3'd1;
  localparam logic [2:0] RB_CHECKSUM = 3'd2;
  localparam logic [2:0] RB_HEADER   = 3'd3;
  localparam logic [2:0] RB_STATUS   = 3'd4;

  // CVITA header without timestamp/SID extras: 8 bytes of header word
  localparam logic [15:0] CVITA_HDR_BYTES = 16'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_BODY  = 2'd2
  } sink_state_t;

  // CVITA length field: payload bytes (4 per IQ sample) plus the header
  function automatic logic [15:0] expected_hdr_len(input logic [15:0] spp);
    return {spp[13:0], 2'b00} + CVITA_HDR_BYTES;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcf_ready_throttle.sv
`default_nettype none
// ============================================================================
//  Module   : mcf_ready_throttle
//  Purpose  : Registered tready generator; asserts ready one cycle in
//             ready_div while enabled (every cycle for ready_div 0 or 1).
//  Revision : 1.0 - initial release
// ============================================================================
module mcf_ready_throttle (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [15:0] ready_div_i,
  output logic        tready_o
);

  logic [15:0] thr_q, thr_d;
  logic        tready_q;

  // Next throttle count: wraps at ready_div-1, frozen at 0 while disabled
  always_comb begin
    thr_d = 16'd0;
    if (enable_i) begin
      if ((ready_div_i <= 16'd1) || (thr_q >= ready_div_i - 16'd1)) begin
        thr_d = 16'd0;
      end else begin
        thr_d = thr_q + 16'd1;
      end
    end
  end

  // Counter and registered ready, so tready tracks thr==0 each cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q    <= 16'd0;
      tready_q <= 1'b0;
    end else begin
      thr_q    <= thr_d;
      tready_q <= enable_i && (thr_d == 16'd0);
    end
  end

  assign tready_o = tready_q;

endmodule
`default_nettype wire

// File: rtl/mcf_stream_sink.sv
`default_nettype none
// ============================================================================
//  Module   : mcf_stream_sink
//  Purpose  : Terminal AXI-stream consumer for McF bring-up: throttled
//             tready, sample/packet counting, length/header checks,
//             running checksum and a registered statistics readback.
//  Revision : 1.0 - initial release
// ============================================================================
module mcf_stream_sink
  import mcf_sink_pkg::*;
#(
  parameter logic [7:0] SR_SINK_ENABLE    = SR_SINK_ENABLE_DFLT,
  parameter logic [7:0] SR_SINK_SPP       = SR_SINK_SPP_DFLT,
  parameter logic [7:0] SR_SINK_READY_DIV = SR_SINK_READY_DIV_DFLT,
  parameter logic [7:0] SR_SINK_CLEAR     = SR_SINK_CLEAR_DFLT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         set_stb,
  input  logic [7:0]   set_addr,
  input  logic [31:0]  set_data,
  input  logic [31:0]  i_tdata,
  input  logic         i_tlast,
  input  logic         i_tvalid,
  output logic         i_tready,
  input  logic [127:0] i_tuser,
  input  logic [2:0]   rb_addr,
  output logic [63:0]  rb_data
);

  logic        enable_q;
  logic [15:0] spp_q, ready_div_q;
  logic        clear;

  sink_state_t st_q, st_d, resume_q, resume_d, ctx, nxt;
  logic [15:0] beat_q, beat_d;
  logic [31:0] sample_q, sample_d, pkt_q, pkt_d;
  logic [31:0] len_err_q, len_err_d, hdr_err_q, hdr_err_d;
  logic [31:0] csum_q, csum_d;
  logic [63:0] hdr_q, hdr_d;
  logic [63:0] rb_q;
  logic        accept;
  logic        unused_bits;

  assign clear       = set_stb && (set_addr == SR_SINK_CLEAR);
  assign accept      = i_tvalid && i_tready;
  assign unused_bits = ^{set_data[31:16], i_tuser[63:0]};

  // Settings registers; writes become visible the cycle after the strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q    <= 1'b0;
      spp_q       <= SPP_RESET;
      ready_div_q <= READY_DIV_RESET;
    end else if (set_stb) begin
      if (set_addr == SR_SINK_ENABLE)    enable_q    <= set_data[0];
      if (set_addr == SR_SINK_SPP)       spp_q       <= set_data[15:0];
      if (set_addr == SR_SINK_READY_DIV) ready_div_q <= set_data[15:0];
    end
  end

  mcf_ready_throttle u_throttle (
    .clk         (clk),
    .reset       (reset),
    .enable_i    (enable_q),
    .ready_div_i (ready_div_q),
    .tready_o    (i_tready)
  );

  // Packet FSM and statistics; IDLE remembers the packet context to resume
  always_comb begin
    resume_d  = resume_q;
    beat_d    = beat_q;
    sample_d  = sample_q;
    pkt_d     = pkt_q;
    len_err_d = len_err_q;
    hdr_err_d = hdr_err_q;
    csum_d    = csum_q;
    hdr_d     = hdr_q;
    ctx       = (st_q == ST_IDLE) ? resume_q : st_q;
    nxt       = ctx;

    if (accept) begin
      sample_d = sample_q + 32'd1;
      csum_d   = csum_q + i_tdata;
      if (ctx == ST_FIRST) begin
        hdr_d = i_tuser[127:64];
        if (i_tuser[111:96] != expected_hdr_len(spp_q)) begin
          hdr_err_d = hdr_err_q + 32'd1;
        end
      end
      if (i_tlast) begin
        if (beat_q + 16'd1 != spp_q) len_err_d = len_err_q + 32'd1;
        pkt_d  = pkt_q + 32'd1;
        beat_d = 16'd0;
        nxt    = ST_FIRST;
      end else if (beat_q == spp_q - 16'd1) begin
        // Overrun: packet reached SPP without tlast, close it here
        len_err_d = len_err_q + 32'd1;
        pkt_d     = pkt_q + 32'd1;
        beat_d    = 16'd0;
        nxt       = ST_FIRST;
      end else begin
        beat_d = beat_q + 16'd1;
        nxt    = ST_BODY;
      end
    end

    resume_d = nxt;
    st_d     = enable_q ? nxt : ST_IDLE;

    // Clear takes priority over any statistics from a simultaneous beat
    if (clear) begin
      sample_d  = 32'd0;
      pkt_d     = 32'd0;
      len_err_d = 32'd0;
      hdr_err_d = 32'd0;
      csum_d    = 32'd0;
      hdr_d     = 64'd0;
    end
  end

  // State and statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= ST_IDLE;
      resume_q  <= ST_FIRST;
      beat_q    <= 16'd0;
      sample_q  <= 32'd0;
      pkt_q     <= 32'd0;
      len_err_q <= 32'd0;
      hdr_err_q <= 32'd0;
      csum_q    <= 32'd0;
      hdr_q     <= 64'd0;
    end else begin
      st_q      <= st_d;
      resume_q  <= resume_d;
      beat_q    <= beat_d;
      sample_q  <= sample_d;
      pkt_q     <= pkt_d;
      len_err_q <= len_err_d;
      hdr_err_q <= hdr_err_d;
      csum_q    <= csum_d;
      hdr_q     <= hdr_d;
    end
  end

  // Registered readback mux, one cycle of latency
  always_ff @(posedge clk) begin
    if (reset) begin
      rb_q <= 64'd0;
    end else begin
      case (rb_addr)
        RB_COUNTS:   rb_q <= {pkt_q, sample_q};
        RB_ERRORS:   rb_q <= {len_err_q, hdr_err_q};
        RB_CHECKSUM: rb_q <= {32'd0, csum_q};
        RB_HEADER:   rb_q <= hdr_q;
        RB_STATUS:   rb_q <= {st_q, 14'd0, beat_q, spp_q, ready_div_q};
        default:     rb_q <= 64'd0;
      endcase
    end
  end

  assign rb_data = rb_q;

endmodule
`default_nettype wire

// File: tb/tb_mcf_stream_sink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mcf_stream_sink
//  Purpose  : Directed self-checking bench for mcf_stream_sink.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mcf_stream_sink;

  logic         clk = 1'b0;
  logic         reset;
  logic         set_stb;
  logic [7:0]   set_addr;
  logic [31:0]  set_data;
  logic [31:0]  i_tdata;
  logic         i_tlast;
  logic         i_tvalid;
  logic         i_tready;
  logic [127:0] i_tuser;
  logic [2:0]   rb_addr;
  logic [63:0]  rb_data;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] HDR_OK  = {16'hA000, 16'd24, 32'h0000_1234};
  localparam logic [63:0] HDR_BAD = {16'hB111, 16'd20, 32'hCAFE_0042};

  mcf_stream_sink dut (
    .clk      (clk),
    .reset    (reset),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .i_tuser  (i_tuser),
    .rb_addr  (rb_addr),
    .rb_data  (rb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge
  task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(negedge clk);
    set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [63:0] hdr);
    logic done;
    done = 1'b0;
    i_tvalid = 1'b1; i_tdata = d; i_tlast = last; i_tuser = {hdr, 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < 100; i++) begin
      if (i_tready) begin
        @(negedge clk);
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
    check("beat_accept", {63'd0, done}, 64'd1);
  endtask

  task automatic read_rb(input logic [2:0] a, output logic [63:0] v);
    rb_addr = a;
    @(negedge clk);
    v = rb_data;
  endtask

  initial begin
    logic [63:0] v;
    int rdy_cnt;
    reset = 1'b1; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
    i_tdata = 32'd0; i_tlast = 1'b0; i_tvalid = 1'b0; i_tuser = 128'd0; rb_addr = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_tready", {63'd0, i_tready}, 64'd0);
    check("reset_rb", rb_data, 64'd0);
    reset = 1'b0;
    read_rb(3'd4, v); check("reset_status", v, 64'h0000_0000_0300_0001);
    read_rb(3'd0, v); check("reset_counts", v, 64'd0);

    // Three clean 4-beat packets, data 1..12
    set_reg(8'd5, 32'd4);
    set_reg(8'd6, 32'd1);
    set_reg(8'd4, 32'd1);
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 4; b++)
        send_beat(32'(p * 4 + b + 1), (b == 3), HDR_OK);
    read_rb(3'd0, v); check("clean_counts", v, {32'd3, 32'd12});
    read_rb(3'd1, v); check("clean_errors", v, 64'd0);
    read_rb(3'd2, v); check("clean_checksum", v, 64'd78);
    read_rb(3'd3, v); check("clean_header", v, HDR_OK);
    read_rb(3'd4, v); check("clean_status", v, 64'h4000_0000_0004_0001);

    // Short packet, then 6-beat packet: overrun at beat 4 and a 2-beat tail
    set_reg(8'd7, 32'd0);
    for (int b = 0; b < 3; b++) send_beat(32'd1, (b == 2), HDR_OK);
    for (int b = 0; b < 6; b++) send_beat(32'd1, (b == 5), HDR_OK);
    read_rb(3'd1, v); check("len_errors", v, {32'd3, 32'd0});
    read_rb(3'd0, v); check("len_counts", v, {32'd3, 32'd9});

    // Header length 20 with spp=4
    set_reg(8'd7, 32'd0);
    for (int b = 0; b < 4; b++) send_beat(32'd2, (b == 3), HDR_BAD);
    read_rb(3'd1, v); check("hdr_errors", v, {32'd0, 32'd1});
    read_rb(3'd3, v); check("hdr_latched", v, HDR_BAD);

    // ready_div=4 with tvalid held for 40 cycles
    set_reg(8'd7, 32'd0);
    set_reg(8'd6, 32'd4);
    rdy_cnt = 0;
    i_tvalid = 1'b1; i_tdata = 32'd0; i_tlast = 1'b0; i_tuser = {HDR_OK, 64'd0};
    for (int c = 0; c < 40; c++) begin
      if (i_tready) rdy_cnt++;
      @(negedge clk);
    end
    i_tvalid = 1'b0;
    check("throttle_ready_cycles", 64'(rdy_cnt), 64'd10);
    read_rb(3'd0, v); check("throttle_counts", v, {32'd2, 32'd10});
    set_reg(8'd6, 32'd1);
    send_beat(32'd0, 1'b0, HDR_OK);
    send_beat(32'd0, 1'b1, HDR_OK);
    read_rb(3'd1, v); check("throttle_errors", v, {32'd2, 32'd0});

    // Clear coincident with an accepted first beat
    check("clr_ready", {63'd0, i_tready}, 64'd1);
    set_stb = 1'b1; set_addr = 8'd7; set_data = 32'd0;
    i_tvalid = 1'b1; i_tdata = 32'd5; i_tlast = 1'b0; i_tuser = {HDR_OK, 64'd0};
    @(negedge clk);
    set_stb = 1'b0; set_addr = 8'd0; i_tvalid = 1'b0;
    read_rb(3'd0, v); check("clr_counts", v, 64'd0);
    read_rb(3'd2, v); check("clr_checksum", v, 64'd0);
    read_rb(3'd3, v); check("clr_header", v, 64'd0);
    for (int b = 0; b < 3; b++) send_beat(32'(6 + b), (b == 2), HDR_OK);
    read_rb(3'd1, v); check("clr_errors", v, 64'd0);
    read_rb(3'd0, v); check("clr_after_counts", v, {32'd1, 32'd3});
    read_rb(3'd2, v); check("clr_after_checksum", v, 64'd21);

    // Enable dropped mid-packet, then resumed
    set_reg(8'd7, 32'd0);
    send_beat(32'd1, 1'b0, HDR_OK);
    send_beat(32'd1, 1'b0, HDR_OK);
    set_reg(8'd4, 32'd0);
    repeat (10) @(negedge clk);
    check("idle_tready", {63'd0, i_tready}, 64'd0);
    read_rb(3'd4, v); check("idle_status", v, 64'h0000_0002_0004_0001);
    set_reg(8'd4, 32'd1);
    send_beat(32'd1, 1'b0, HDR_OK);
    send_beat(32'd1, 1'b1, HDR_OK);
    read_rb(3'd1, v); check("resume_errors", v, 64'd0);
    read_rb(3'd0, v); check("resume_counts", v, {32'd1, 32'd4});
    read_rb(3'd5, v); check("rb_unused", v, 64'd0);

    // Reset in the middle of a packet
    send_beat(32'd3, 1'b0, HDR_OK);
    send_beat(32'd3, 1'b0, HDR_OK);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_tready", {63'd0, i_tready}, 64'd0);
    read_rb(3'd0, v); check("midreset_counts", v, 64'd0);
    read_rb(3'd4, v); check("midreset_status", v, 64'h0000_0000_0300_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mcf_stream_sink.md
Name: mcf_stream_sink

Overview:
- Terminal AXI-stream consumer placed directly downstream of the McF sample source, in the same RFNoC CE, for bring-up and soak tests.
- Accepts 32-bit IQ beats with sideband CVITA header (tuser) under a programmable tready throttle.
- Counts samples and packets, checks packet length and header length against the configured SPP, and keeps a running checksum.
- Exposes all statistics through a registered readback mux.

Parameters:
SR_SINK_ENABLE, 4, setting-register address of 1-bit enable
SR_SINK_SPP, 5, address of 16-bit expected IQ samples per packet (reset 768)
SR_SINK_READY_DIV, 6, address of 16-bit tready divider (reset 1)
SR_SINK_CLEAR, 7, address whose write strobe clears statistics (data ignored)

Ports:
clk  in  1  block clock
reset  in  1  synchronous, active-high reset
set_stb  in  1  settings bus strobe
set_addr  in  8  settings bus address
set_data  in  32  settings bus data
i_tdata  in  32  IQ sample {I[31:16], Q[15:0]}
i_tlast  in  1  last beat of packet
i_tvalid  in  1  beat valid
i_tready  out  1  beat accept
i_tuser  in  128  CVITA header {hdr64, vita_time64}; sampled on first beat of packet
rb_addr  in  3  readback select
rb_data  out  64  registered readback data

Behaviour:
- Reset: i_tready=0, rb_data=0, all counters/checksum/last_hdr=0, state=IDLE, beat_cnt=0, throttle counter=0; settings regs return to their defaults (enable=0, spp=768, ready_div=1).
- Handshake: a beat is accepted when i_tvalid && i_tready on a rising edge. i_tready is registered and never depends combinationally on i_tvalid.
- Throttle: 16-bit counter thr runs only while enable=1. i_tready=1 in cycles where thr==0; thr wraps at ready_div-1. ready_div of 0 or 1 gives i_tready=1 every cycle. ready_div=4 gives exactly 1 ready cycle in 4.
- FSM states:
  - IDLE: enable=0. i_tready=0, thr held at 0, counters hold. On enable=1, move to FIRST.
  - FIRST: awaiting beat 0 of a packet. On accept:
    - latch last_hdr=i_tuser[127:64];
    - if i_tuser[111:96] != (spp<<2)+8, hdr_err_cnt+1;
    - if i_tlast, stay in FIRST and apply the tlast check below; else beat_cnt=1 and move to BODY.
  - BODY: on each accept, beat_cnt+1. On an i_tlast beat, go to FIRST and set beat_cnt=0.
- Length checks:
  - tlast check: on any tlast beat, if beat_cnt+1 != spp, len_err_cnt+1.
  - Overrun: on a non-tlast beat with beat_cnt==spp-1, len_err_cnt+1, beat_cnt=0, go to FIRST (the packet is forcibly closed).
  - spp==0: every packet flags a length error.
- Enable deasserted mid-packet: go to IDLE but keep beat_cnt and the BODY/FIRST context; on re-enable, resume that state.
- Statistics (all wrap mod 2^32):
  - sample_cnt+1 per accepted beat.
  - pkt_cnt+1 per accepted tlast beat or overrun close.
  - checksum += i_tdata per accepted beat.
- Clear: set_stb with set_addr==SR_SINK_CLEAR zeroes sample_cnt, pkt_cnt, len_err_cnt, hdr_err_cnt, checksum and last_hdr in that cycle. Clear wins over a simultaneous accept, so that beat's statistics are dropped. beat_cnt and FSM are unaffected.
- Settings changes take effect the cycle after the strobe. Changing spp mid-packet uses the new value from then on.
- Readback: rb_data registered, 1-cycle latency.
  - 0: {pkt_cnt, sample_cnt}
  - 1: {len_err_cnt, hdr_err_cnt}
  - 2: {32'd0, checksum}
  - 3: last_hdr
  - 4: {state, 14'd0, beat_cnt, spp, ready_div}, with state=2 bits (IDLE=0, FIRST=1, BODY=2)
  - 5-7: 0
- Reset mid-packet: everything returns to reset values the next cycle. The partial packet is not counted.

Decomposition:
- Package mcf_sink_pkg: SR_* address defaults, readback address constants RB_COUNTS=0, RB_ERRORS=1, RB_CHECKSUM=2, RB_HEADER=3, RB_STATUS=4, FSM state encodings, CVITA_HDR_BYTES=8.
- One sub-module: mcf_ready_throttle (enable, ready_div -> registered tready).
- Settings use the existing setting_reg.

Test Plan:
- Reset, enable, spp=4, ready_div=1; send 3 packets of 4 beats, data 1..12, header length 24 -> pkt_cnt=3, sample_cnt=12, checksum=78, both error counts 0.
- spp=4; send a 3-beat packet with tlast, then a 6-beat packet without tlast until beat 6 -> len_err_cnt=3 (short packet, overrun at beat 4, 2-beat tail), pkt_cnt=3.
- Header length field 20 with spp=4 -> hdr_err_cnt=1; last_hdr equals the sent i_tuser[127:64].
- ready_div=4, tvalid held high for 40 cycles -> exactly 10 beats accepted, i_tready high one cycle in four.
- Clear strobe coincident with an accepted beat -> all statistics 0 afterwards; the next packet still completes with no length error.
- Deassert enable after beat 2 of a 4-beat packet, wait 10 cycles, re-enable and send 2 beats ending in tlast -> no length error, pkt_cnt+1.
